mix_columns_seq: RTL and testbench

- Sequential AES MixColumns stage. It sits directly downstream of the combinational ShiftRows stage and consumes its 128-bit o_block.
- It processes the state COLS_PER_CYCLE columns per clock, which trades area for latency.
- It uses a valid/ready handshake on both sides and returns the result to the round datapath (AddRoundKey).
- A bypass input passes the block through unchanged, because the final AES round omits MixColumns.

---
 rtl/aes_pkg.sv | 30 +++
 rtl/mix_column_word.sv | 75 +++++++
 rtl/mix_columns_seq.sv | 153 +++++++++++++++
 tb/tb_mix_columns_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES datapath types, constants and GF(2^8) helpers.
//   byte_t / word_t / block_t : 8 / 32 / 128-bit datapath containers
//   AES_POLY                  : reduction term of x^8+x^4+x^3+x+1
//   NUM_COLS                  : columns in one AES state
//   state_e                   : MixColumns sequencer FSM encoding
//   xtime()                   : multiply a byte by 2 in GF(2^8)
// -----------------------------------------------------------------------------
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  localparam byte_t AES_POLY = 8'h1B;
  localparam int    NUM_COLS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Multiply by x in GF(2^8); reduce when the top bit falls off.
  function automatic byte_t xtime(input byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// -----------------------------------------------------------------------------
// mix_column_word
// Combinational MixColumns on one 32-bit column (row-0 byte in the MSBs).
// Optional macro MIX_COLUMNS_INV_EN adds the inverse transform.
//   col_i : input column a0..a3
//   inv_i : (MIX_COLUMNS_INV_EN only) 1 selects InvMixColumns
//   col_o : mixed column b0..b3
// -----------------------------------------------------------------------------
module mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
`ifdef MIX_COLUMNS_INV_EN
  input  logic        inv_i,
`endif
  output logic [31:0] col_o
);

  byte_t a_s  [4];
  byte_t x2_s [4];
  byte_t x3_s [4];
  word_t fwd_s;

  // Split the column into bytes and form the 2x / 3x multiples.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_s[i]  = col_i[31-8*i -: 8];
      x2_s[i] = xtime(a_s[i]);
      x3_s[i] = x2_s[i] ^ a_s[i];
    end
  end

  // Forward matrix rows {2 3 1 1} rotated per output byte.
  always_comb begin
    fwd_s[31:24] = x2_s[0] ^ x3_s[1] ^ a_s[2]  ^ a_s[3];
    fwd_s[23:16] = a_s[0]  ^ x2_s[1] ^ x3_s[2] ^ a_s[3];
    fwd_s[15:8]  = a_s[0]  ^ a_s[1]  ^ x2_s[2] ^ x3_s[3];
    fwd_s[7:0]   = x3_s[0] ^ a_s[1]  ^ a_s[2]  ^ x2_s[3];
  end

`ifdef MIX_COLUMNS_INV_EN
  byte_t x4_s [4];
  byte_t x8_s [4];
  byte_t m9_s [4];
  byte_t mb_s [4];
  byte_t md_s [4];
  byte_t me_s [4];
  word_t inv_s;

  // Inverse coefficients from the 2x/4x/8x chain: 9=8+1, B=8+2+1, D=8+4+1, E=8+4+2.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      x4_s[i] = xtime(x2_s[i]);
      x8_s[i] = xtime(x4_s[i]);
      m9_s[i] = x8_s[i] ^ a_s[i];
      mb_s[i] = x8_s[i] ^ x2_s[i] ^ a_s[i];
      md_s[i] = x8_s[i] ^ x4_s[i] ^ a_s[i];
      me_s[i] = x8_s[i] ^ x4_s[i] ^ x2_s[i];
    end
  end

  // Inverse matrix rows {E B D 9} rotated per output byte.
  always_comb begin
    inv_s[31:24] = me_s[0] ^ mb_s[1] ^ md_s[2] ^ m9_s[3];
    inv_s[23:16] = m9_s[0] ^ me_s[1] ^ mb_s[2] ^ md_s[3];
    inv_s[15:8]  = md_s[0] ^ m9_s[1] ^ me_s[2] ^ mb_s[3];
    inv_s[7:0]   = mb_s[0] ^ md_s[1] ^ m9_s[2] ^ me_s[3];
  end

  assign col_o = inv_i ? inv_s : fwd_s;
`else
  assign col_o = fwd_s;
`endif

endmodule

// File: rtl/mix_columns_seq.sv
// -----------------------------------------------------------------------------
// mix_columns_seq
// Sequential AES MixColumns stage between ShiftRows and AddRoundKey. Mixes
// COLS_PER_CYCLE columns per clock in place in a work register, then presents
// the block until the downstream accepts it. i_last bypasses the mixing.
// Optional macro MIX_COLUMNS_INV_EN adds i_inv (inverse transform select).
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_valid, o_ready  : upstream handshake, i_block/i_last(/i_inv) sampled on transfer
//   o_valid, i_ready  : downstream handshake, o_block held stable while o_valid
// -----------------------------------------------------------------------------
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_block,
  input  logic         i_last,
`ifdef MIX_COLUMNS_INV_EN
  input  logic         i_inv,
`endif
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_block
);

  // Counter value of the cycle that mixes column 3, and per-cycle advance.
  localparam logic [1:0] LAST_CNT = 2'(NUM_COLS - COLS_PER_CYCLE);
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

  state_e     state_q, state_d;
  block_t     work_q, work_d;
  block_t     out_q;
  logic [1:0] col_q, col_d;
  logic       valid_q;
  logic       ready_q;
  logic       inv_q, inv_d;

  word_t col_in_s  [COLS_PER_CYCLE];
  word_t col_mix_s [COLS_PER_CYCLE];

  function automatic word_t get_col(input block_t b, input logic [1:0] idx);
    word_t w;
    case (idx)
      2'd1:    w = b[95:64];
      2'd2:    w = b[63:32];
      2'd3:    w = b[31:0];
      default: w = b[127:96];
    endcase
    return w;
  endfunction

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_in_s[g] = get_col(work_q, col_q + 2'(g));

    mix_column_word u_mix (
      .col_i (col_in_s[g]),
`ifdef MIX_COLUMNS_INV_EN
      .inv_i (inv_q),
`endif
      .col_o (col_mix_s[g])
    );
  end

`ifdef MIX_COLUMNS_INV_EN
  logic inv_in_s;
  assign inv_in_s = i_inv;
`else
  logic inv_in_s;
  assign inv_in_s = 1'b0;
`endif

  // Next-state, work register update and column counter.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    col_d   = col_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          work_d = i_block;
          inv_d  = inv_in_s;
          col_d  = 2'd0;
          state_d = i_last ? DONE : BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // Overwrite only the columns this cycle's mixers are working on.
        for (int c = 0; c < NUM_COLS; c++) begin
          for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            work_d[127-32*c -: 32] = (2'(c) == (col_q + 2'(k))) ?
                                     col_mix_s[k] : work_d[127-32*c -: 32];
          end
        end
        if (col_q == LAST_CNT) begin
          state_d = DONE;
          col_d   = 2'd0;
        end else begin
          state_d = BUSY;
          col_d   = col_q + CNT_STEP;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        col_d   = 2'd0;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      out_q   <= '0;
      col_q   <= 2'd0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      col_q   <= col_d;
      inv_q   <= inv_d;
      valid_q <= (state_d == DONE);
      ready_q <= (state_d == IDLE);
      // Publish only the finished block, never a partially mixed one.
      if ((state_d == DONE) && (state_q != DONE)) begin
        out_q <= work_d;
      end else begin
        out_q <= out_q;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_ready = ready_q;
  assign o_block = out_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
module tb_mix_columns_seq;

  typedef struct {
    logic [127:0] blk;
    logic         last;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] R1_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] R1_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

  logic         clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic [127:0] i_block;
  logic         i_last;
  logic         i_ready;
`ifdef MIX_COLUMNS_INV_EN
  logic         i_inv;
`endif
  logic [2:0]   ov;
  logic [2:0]   ordy;
  logic [127:0] ob [3];

  int checks = 0;
  int errors = 0;
  int cpc [3] = '{1, 2, 4};
  vec_t tbl [$];

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u_c1 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(ordy[0]),
    .i_block(i_block), .i_last(i_last),
`ifdef MIX_COLUMNS_INV_EN
    .i_inv(i_inv),
`endif
    .o_valid(ov[0]), .i_ready(i_ready), .o_block(ob[0]));

  mix_columns_seq #(.COLS_PER_CYCLE(2)) u_c2 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(ordy[1]),
    .i_block(i_block), .i_last(i_last),
`ifdef MIX_COLUMNS_INV_EN
    .i_inv(i_inv),
`endif
    .o_valid(ov[1]), .i_ready(i_ready), .o_block(ob[1]));

  mix_columns_seq #(.COLS_PER_CYCLE(4)) u_c4 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(ordy[2]),
    .i_block(i_block), .i_last(i_last),
`ifdef MIX_COLUMNS_INV_EN
    .i_inv(i_inv),
`endif
    .o_valid(ov[2]), .i_ready(i_ready), .o_block(ob[2]));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int k = 0; k < 20 && ordy != 3'b111; k++) begin
      @(posedge clk); #1;
    end
    check({tag, "_ready"}, 128'(ordy), 128'(3'b111));
  endtask

  // Send one block with i_ready high; record the edge count (acceptance edge
  // is edge 1) at which each instance first raises o_valid.
  task automatic run_vec(input vec_t v, input string tag);
    int           lat [3];
    logic [127:0] res [3];
    int           exp_lat;
    for (int d = 0; d < 3; d++) begin
      lat[d] = 0;
      res[d] = '0;
    end
    wait_ready(tag);
    i_block = v.blk;
    i_last  = v.last;
`ifdef MIX_COLUMNS_INV_EN
    i_inv   = v.inv;
`endif
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      for (int d = 0; d < 3; d++) begin
        if (lat[d] == 0 && ov[d]) begin
          lat[d] = e;
          res[d] = ob[d];
        end
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 3; d++) begin
      exp_lat = v.last ? 1 : (4 / cpc[d]) + 1;
      check($sformatf("%s_lat_cpc%0d", tag, cpc[d]), 128'(lat[d]), 128'(exp_lat));
      check($sformatf("%s_blk_cpc%0d", tag, cpc[d]), res[d], v.exp);
    end
  endtask

  initial begin
    logic [127:0] snap [3];

    tbl.push_back('{128'hdb135345db135345db135345db135345, 1'b0, 1'b0,
                    128'h8e4da1bc8e4da1bc8e4da1bc8e4da1bc});
    tbl.push_back('{128'hf20a225cf20a225cf20a225cf20a225c, 1'b0, 1'b0,
                    128'h9fdc589d9fdc589d9fdc589d9fdc589d});
    tbl.push_back('{128'hc6c6c6c6c6c6c6c6c6c6c6c6c6c6c6c6, 1'b0, 1'b0,
                    128'hc6c6c6c6c6c6c6c6c6c6c6c6c6c6c6c6});
    tbl.push_back('{128'hd4d4d4d5d4d4d4d5d4d4d4d5d4d4d4d5, 1'b0, 1'b0,
                    128'hd5d5d7d6d5d5d7d6d5d5d7d6d5d5d7d6});
    tbl.push_back('{R1_IN, 1'b0, 1'b0, R1_OUT});
    tbl.push_back('{R1_IN, 1'b1, 1'b0, R1_IN});
`ifdef MIX_COLUMNS_INV_EN
    tbl.push_back('{R1_OUT, 1'b0, 1'b1, R1_IN});
    tbl.push_back('{R1_OUT, 1'b1, 1'b1, R1_OUT});
`endif

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_block = '0;
    i_last  = 1'b0;
    i_ready = 1'b1;
`ifdef MIX_COLUMNS_INV_EN
    i_inv   = 1'b0;
`endif
    #1;
    check("rst_valid", 128'(ov), 128'(3'b000));
    check("rst_ready", 128'(ordy), 128'(3'b000));
    for (int d = 0; d < 3; d++) check($sformatf("rst_blk%0d", d), ob[d], 128'h0);
    @(posedge clk); @(posedge clk); #1;
    i_rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Back-pressure: hold results in DONE, try a second block meanwhile.
    i_ready = 1'b0;
    wait_ready("bp");
    i_block = R1_IN;
    i_last  = 1'b0;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (int k = 0; k < 10 && ov != 3'b111; k++) begin
      @(posedge clk); #1;
    end
    check("bp_valid_up", 128'(ov), 128'(3'b111));
    for (int d = 0; d < 3; d++) begin
      snap[d] = ob[d];
      check($sformatf("bp_result%0d", d), ob[d], R1_OUT);
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc == 4) begin
        i_block = 128'h0123456789abcdef0123456789abcdef;
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      check($sformatf("bp_valid_c%0d", cyc), 128'(ov), 128'(3'b111));
      check($sformatf("bp_ready_c%0d", cyc), 128'(ordy), 128'(3'b000));
      for (int d = 0; d < 3; d++) check($sformatf("bp_stable_c%0d_%0d", cyc, d), ob[d], snap[d]);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 128'(ov), 128'(3'b000));
    check("bp_release_ready", 128'(ordy), 128'(3'b111));
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_no_second_%0d", k), 128'(ov), 128'(3'b000));
    end

    // Reset in the middle of BUSY, then recover with a fresh block.
    wait_ready("rb");
    i_block = R1_IN;
    i_last  = 1'b0;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    i_rst = 1'b1;
    #1;
    check("rb_valid", 128'(ov), 128'(3'b000));
    check("rb_ready", 128'(ordy), 128'(3'b000));
    for (int d = 0; d < 3; d++) check($sformatf("rb_blk%0d", d), ob[d], 128'h0);
    @(posedge clk); @(posedge clk); #1;
    i_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("rb_quiet_%0d", k), 128'(ov), 128'(3'b000));
    end
    run_vec(tbl[4], "rb_recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
